alsu_arbiter: RTL and testbench

- Shares one ALSU instance between two requesters (req0, req1) through valid/ready handshakes; issues at most one operation per cycle into the ALSU.
- Tracks in-flight operations with a tag pipeline matched to the ALSU register latency and returns each result to its originator as a one-cycle response pulse.
- Owns ALSU reset sequencing: drives the ALSU active-high reset from this block's synchronous active-low reset.

---
 rtl/alsu_arbiter.sv | 138 +++++++++++++
 tb/tb_alsu_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_arbiter.sv
// Shares one ALSU between two valid/ready requesters, tags in-flight ops, returns results as rsp pulses.
// Latency: accept in cycle T -> rsp_valid in T+LATENCY+1; 1 op/cycle, responses in acceptance order.
// Backpressure: reqN_ready only in RUN and only for the granted side; responses cannot be stalled.
module alsu_arbiter #(
    parameter int    LATENCY    = 2,
    parameter int    RST_CYCLES = 2,
    parameter string ARB_MODE   = "RR"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_a,
    input  logic [2:0]  req0_b,
    input  logic [2:0]  req0_opc,
    input  logic [6:0]  req0_ctrl,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_a,
    input  logic [2:0]  req1_b,
    input  logic [2:0]  req1_opc,
    input  logic [6:0]  req1_ctrl,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [5:0]  rsp_data,
    output logic [2:0]  alsu_A,
    output logic [2:0]  alsu_B,
    output logic [2:0]  alsu_opc,
    output logic [6:0]  alsu_ctrl,
    output logic        alsu_rst,
    input  logic [5:0]  alsu_out,
    output logic        busy,
    output logic [15:0] op_count
);

    localparam bit         FIXED_PRIO = (ARB_MODE == "REQ0");
    localparam logic [3:0] RST_LOAD   = 4'(RST_CYCLES);

    typedef enum logic {ST_RESET, ST_RUN} state_t;

    state_t             state;
    logic [3:0]         rst_cnt;
    logic               rr_ptr;
    logic [LATENCY-1:0] tag_vld;
    logic [LATENCY-1:0] tag_id;
    logic               grant_vld;
    logic               grant_id;

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (state == ST_RUN) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = FIXED_PRIO ? 1'b0 : rr_ptr;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld && grant_id;

    // Non-transfer cycles drive an all-zero bundle so the ALSU output decays to 0.
    always_comb begin
        alsu_A    = '0;
        alsu_B    = '0;
        alsu_opc  = '0;
        alsu_ctrl = '0;
        if (grant_vld) begin
            if (grant_id) begin
                alsu_A    = req1_a;
                alsu_B    = req1_b;
                alsu_opc  = req1_opc;
                alsu_ctrl = req1_ctrl;
            end else begin
                alsu_A    = req0_a;
                alsu_B    = req0_b;
                alsu_opc  = req0_opc;
                alsu_ctrl = req0_ctrl;
            end
        end
    end

    assign busy = (|tag_vld) || rsp_valid;

    // The response register acts as the final tag stage, so tag_vld[LATENCY-1]
    // lines up with the ALSU result of that op being present on alsu_out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_RESET;
            rst_cnt  <= RST_LOAD;
            alsu_rst <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_data <= '0;
            tag_vld  <= '0;
            tag_id   <= '0;
            rr_ptr   <= 1'b0;
            op_count <= '0;
        end else begin
            if (state == ST_RESET) begin
                if (rst_cnt <= 4'd1) begin
                    state    <= ST_RUN;
                    alsu_rst <= 1'b0;
                    rst_cnt  <= '0;
                end else begin
                    rst_cnt <= rst_cnt - 4'd1;
                end
            end

            tag_vld[0] <= grant_vld;
            tag_id[0]  <= grant_id;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end

            if (grant_vld) begin
                rr_ptr   <= ~grant_id;
                op_count <= op_count + 16'd1;
            end

            if (tag_vld[LATENCY-1]) begin
                rsp_valid <= 1'b1;
                rsp_id    <= tag_id[LATENCY-1];
                rsp_data  <= alsu_out;
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alsu_arbiter.sv
// Directed bench for alsu_arbiter: RR instance plus a REQ0-mode instance, each driving its own ALSU model.
module tb_alsu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [2:0]  req0_a, req0_b, req0_opc, req1_a, req1_b, req1_opc;
    logic [6:0]  req0_ctrl, req1_ctrl;

    logic        req0_ready, req1_ready, rsp_valid, rsp_id, alsu_rst, busy;
    logic [5:0]  rsp_data, alsu_out;
    logic [2:0]  alsu_A, alsu_B, alsu_opc;
    logic [6:0]  alsu_ctrl;
    logic [15:0] op_count;

    logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_alsu_rst, f_busy;
    logic [5:0]  f_rsp_data, f_alsu_out;
    logic [2:0]  f_alsu_A, f_alsu_B, f_alsu_opc;
    logic [6:0]  f_alsu_ctrl;
    logic [15:0] f_op_count;

    int n_tests = 0;
    int n_fail  = 0;

    alsu_arbiter #(.LATENCY(2), .RST_CYCLES(2), .ARB_MODE("RR")) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_opc(req0_opc), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_opc(req1_opc), .req1_ctrl(req1_ctrl),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opc(alsu_opc), .alsu_ctrl(alsu_ctrl),
        .alsu_rst(alsu_rst), .alsu_out(alsu_out), .busy(busy), .op_count(op_count)
    );

    alsu_arbiter #(.LATENCY(2), .RST_CYCLES(2), .ARB_MODE("REQ0")) u_dut_fix (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_opc(req0_opc), .req0_ctrl(req0_ctrl),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_opc(req1_opc), .req1_ctrl(req1_ctrl),
        .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data),
        .alsu_A(f_alsu_A), .alsu_B(f_alsu_B), .alsu_opc(f_alsu_opc), .alsu_ctrl(f_alsu_ctrl),
        .alsu_rst(f_alsu_rst), .alsu_out(f_alsu_out), .busy(f_busy), .op_count(f_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALSU behaviour: ctrl = {cin, sin, dir, ropA, ropB, bpA, bpB}; shifts act on the current output.
    function automatic logic [5:0] alsu_f(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] opc, input logic [6:0] c,
                                          input logic [5:0] prev);
        logic [5:0] r;
        r = '0;
        if (c[1]) r = {3'b000, a};
        else if (c[0]) r = {3'b000, b};
        else begin
            case (opc)
                3'b000: r = c[3] ? {5'b0, &a} : (c[2] ? {5'b0, &b} : {3'b000, a & b});
                3'b001: r = c[3] ? {5'b0, ^a} : (c[2] ? {5'b0, ^b} : {3'b000, a ^ b});
                3'b010: r = 6'(a) + 6'(b) + 6'(c[6]);
                3'b011: r = 6'(a) * 6'(b);
                3'b100: r = c[4] ? {prev[4:0], c[5]} : {c[5], prev[5:1]};
                3'b101: r = c[4] ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    logic [2:0] m_a, m_b, m_opc, fm_a, fm_b, fm_opc;
    logic [6:0] m_ctrl, fm_ctrl;
    logic [5:0] m_out, fm_out;

    always @(posedge clk) begin
        if (alsu_rst) begin
            m_a <= '0; m_b <= '0; m_opc <= '0; m_ctrl <= '0; m_out <= '0;
        end else begin
            m_a <= alsu_A; m_b <= alsu_B; m_opc <= alsu_opc; m_ctrl <= alsu_ctrl;
            m_out <= alsu_f(m_a, m_b, m_opc, m_ctrl, m_out);
        end
    end

    always @(posedge clk) begin
        if (f_alsu_rst) begin
            fm_a <= '0; fm_b <= '0; fm_opc <= '0; fm_ctrl <= '0; fm_out <= '0;
        end else begin
            fm_a <= f_alsu_A; fm_b <= f_alsu_B; fm_opc <= f_alsu_opc; fm_ctrl <= f_alsu_ctrl;
            fm_out <= alsu_f(fm_a, fm_b, fm_opc, fm_ctrl, fm_out);
        end
    end

    assign alsu_out   = m_out;
    assign f_alsu_out = fm_out;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic drive0(input logic [2:0] a, input logic [2:0] b, input logic [2:0] opc,
                          input logic [6:0] c);
        req0_a = a; req0_b = b; req0_opc = opc; req0_ctrl = c; req0_valid = 1'b1;
    endtask

    task automatic drive1(input logic [2:0] a, input logic [2:0] b, input logic [2:0] opc,
                          input logic [6:0] c);
        req1_a = a; req1_b = b; req1_opc = opc; req1_ctrl = c; req1_valid = 1'b1;
    endtask

    task automatic idle_all();
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_all();
        req0_a = '0; req0_b = '0; req0_opc = '0; req0_ctrl = '0;
        req1_a = '0; req1_b = '0; req1_opc = '0; req1_ctrl = '0;
        repeat (3) @(posedge clk);

        // Release reset with req0 already waiting: it must not be accepted until RUN.
        @(negedge clk);
        rst = 1'b1;
        drive0(3'd3, 3'd5, 3'b010, 7'b1000000);
        #1;
        chk("rst_alsu_rst_c1", alsu_rst, 1);
        chk("rst_ready0_c1", req0_ready, 0);
        chk("rst_idle_A", alsu_A, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_op_count", op_count, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk); #1;
        chk("rst_alsu_rst_c2", alsu_rst, 1);
        chk("rst_ready0_c2", req0_ready, 0);

        // Single op: 3 + 5 + cin = 9, accepted in this cycle (T).
        @(negedge clk); #1;
        chk("run_alsu_rst", alsu_rst, 0);
        chk("single_ready0", req0_ready, 1);
        chk("single_ready1", req1_ready, 0);
        chk("single_alsu_A", alsu_A, 3);
        chk("single_alsu_B", alsu_B, 5);
        chk("single_alsu_opc", alsu_opc, 2);
        chk("single_alsu_ctrl", alsu_ctrl, 7'b1000000);
        @(negedge clk); req0_valid = 1'b0; #1;
        chk("single_op_count", op_count, 1);
        chk("single_busy", busy, 1);
        chk("single_idle_A", alsu_A, 0);
        chk("single_rsp_t1", rsp_valid, 0);
        @(negedge clk); #1;
        chk("single_rsp_t2", rsp_valid, 0);
        @(negedge clk); #1;
        chk("single_rsp_valid", rsp_valid, 1);
        chk("single_rsp_id", rsp_id, 0);
        chk("single_rsp_data", rsp_data, 9);
        @(negedge clk); #1;
        chk("single_rsp_t4", rsp_valid, 0);
        chk("single_data_hold", rsp_data, 9);
        chk("single_busy_done", busy, 0);

        // Two accepts, then reset while both are still in flight.
        @(negedge clk);
        drive1(3'd3, 3'd3, 3'b011, 7'b0000000);
        #1;
        chk("mid_ready1", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        drive0(3'd1, 3'd2, 3'b010, 7'b0000000);
        #1;
        chk("mid_ready0", req0_ready, 1);
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        #1;
        chk("mid_op_count_pre", op_count, 3);
        chk("mid_busy_pre", busy, 1);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("mid_rsp_valid", rsp_valid, 0);
            chk("mid_busy", busy, 0);
            chk("mid_op_count", op_count, 0);
            chk("mid_alsu_rst", alsu_rst, (i < 2) ? 1 : 0);
            @(negedge clk);
        end

        // Contention: RR alternates 0,1,0,1; REQ0 instance always grants req0.
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                drive0(3'd7, 3'd7, 3'b011, 7'b0000000);
                drive1(3'd6, 3'd3, 3'b000, 7'b0000000);
            end else begin
                idle_all();
            end
            #1;
            if (i < 4) begin
                chk("rr_ready0", req0_ready, (i % 2 == 0) ? 1 : 0);
                chk("rr_ready1", req1_ready, (i % 2 == 1) ? 1 : 0);
                chk("fix_ready0", f_req0_ready, 1);
                chk("fix_ready1", f_req1_ready, 0);
            end
            if (i >= 3 && i < 7) begin
                chk("rr_rsp_valid", rsp_valid, 1);
                chk("rr_rsp_id", rsp_id, ((i - 3) % 2 == 1) ? 1 : 0);
                chk("rr_rsp_data", rsp_data, ((i - 3) % 2 == 1) ? 2 : 49);
                chk("fix_rsp_valid", f_rsp_valid, 1);
                chk("fix_rsp_id", f_rsp_id, 0);
                chk("fix_rsp_data", f_rsp_data, 49);
            end
            if (i == 7) begin
                chk("rr_rsp_end", rsp_valid, 0);
                chk("fix_rsp_end", f_rsp_valid, 0);
            end
            @(negedge clk);
        end

        // Back-to-back: bypass A=5, then shift left with sin=1 -> 6'b001011.
        drive0(3'd5, 3'd0, 3'b000, 7'b0000010);
        #1;
        chk("b2b_ready0_a", req0_ready, 1);
        @(negedge clk);
        drive0(3'd0, 3'd0, 3'b100, 7'b0110000);
        #1;
        chk("b2b_ready0_b", req0_ready, 1);
        chk("b2b_alsu_opc", alsu_opc, 4);
        @(negedge clk);
        idle_all();
        @(negedge clk); #1;
        chk("b2b_rsp_valid_a", rsp_valid, 1);
        chk("b2b_rsp_data_a", rsp_data, 5);
        @(negedge clk); #1;
        chk("b2b_rsp_valid_b", rsp_valid, 1);
        chk("b2b_rsp_id_b", rsp_id, 0);
        chk("b2b_rsp_data_b", rsp_data, 6'b001011);
        @(negedge clk);
        @(negedge clk);
        drive0(3'd0, 3'd0, 3'b100, 7'b0110000);
        #1;
        chk("gap_ready0", req0_ready, 1);
        @(negedge clk);
        idle_all();
        @(negedge clk);
        @(negedge clk); #1;
        chk("gap_rsp_valid", rsp_valid, 1);
        chk("gap_rsp_data", rsp_data, 6'b000001);
        @(negedge clk); #1;
        chk("final_op_count", op_count, 7);
        chk("final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
